// File: rtl/pbm_pkg.sv
// pbm_pkg: shared definitions for the PBM read-side DMA drain engine.
//   pbm_state_e     - drain FSM states (IDLE, CMD, DATA)
//   BYTES_PER_WORD  - bytes per PBM word / memory beat at the default 32-bit width
//   LEN_W           - width of burst-length fields (holds 1..256)
package pbm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } pbm_state_e;

  localparam int unsigned BYTES_PER_WORD = 32 / 8;
  localparam int unsigned LEN_W          = 9;

endpackage

// File: rtl/pbm_prefetch_fifo.sv
// pbm_prefetch_fifo: small synchronous FIFO that absorbs PBM read latency.
//   clk, rst_n  - clock, synchronous active-low clear (pointers and count)
//   push, push_data - write one word
//   pop         - consume the head word (only while non-empty)
//   head        - current head word (first-word fall-through)
//   count       - number of stored words, 0..DEPTH
//   empty       - count == 0
module pbm_prefetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);

  // The prefetch credit check upstream guarantees a free slot for every word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt == CW'(DEPTH))));

endmodule

// File: rtl/pbm_dma_reader.sv
// pbm_dma_reader: drains committed PBM words into bursts toward a memory ring buffer.
//   clk, rst_n          - clock, synchronous active-low reset
//   i_enable            - allow new bursts to start
//   i_base_addr         - ring base byte address
//   i_ring_words        - ring size in words
//   o_pbm_rd_en         - PBM pop request
//   i_pbm_rd_data/valid - PBM read data, one cycle after the pop
//   i_pbm_rd_empty      - PBM holds no committed data
//   i_pbm_usage         - committed PBM words
//   o_cmd_*/i_cmd_ready - burst command (addr, len) handshake
//   o_dat_*/i_dat_ready - data beat handshake with last-beat flag
//   o_busy              - FSM not in IDLE
//   o_words_total       - wrapping count of delivered words
// Build option: define PBM_DMA_FLUSH_TIMEOUT_EN to let a partial burst go out
// after FLUSH_CYCLES idle cycles with 0 < usage < MAX_BURST.
module pbm_dma_reader
  import pbm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PBM_ADDR_WIDTH = 14,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FLUSH_CYCLES   = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [15:0]               i_ring_words,
  output logic                      o_pbm_rd_en,
  input  logic [DATA_WIDTH-1:0]     i_pbm_rd_data,
  input  logic                      i_pbm_rd_valid,
  input  logic                      i_pbm_rd_empty,
  input  logic [PBM_ADDR_WIDTH:0]   i_pbm_usage,
  output logic                      o_cmd_valid,
  input  logic                      i_cmd_ready,
  output logic [ADDR_WIDTH-1:0]     o_cmd_addr,
  output logic [8:0]                o_cmd_len,
  output logic                      o_dat_valid,
  input  logic                      i_dat_ready,
  output logic [DATA_WIDTH-1:0]     o_dat_data,
  output logic                      o_dat_last,
  output logic                      o_busy,
  output logic [31:0]               o_words_total
);

  localparam int unsigned BPW = DATA_WIDTH / 8;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned UW  = PBM_ADDR_WIDTH + 1;

  pbm_state_e            state, state_next;
  logic [15:0]           wr_ptr;
  logic [LEN_W-1:0]      len, len_next, issued, beats;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           fill;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push, dat_fire, last_beat, prefetch_ok;
  logic                  start, done, eligible, flush_due;
  logic [16:0]           room, usage_x, max_x, ptr_sum;

  // Burst length is the smallest of committed words, MAX_BURST and ring room.
  assign room    = {1'b0, i_ring_words} - {1'b0, wr_ptr};
  assign usage_x = 17'(i_pbm_usage);
  assign max_x   = 17'(MAX_BURST);

  always_comb begin
    if (usage_x <= max_x && usage_x <= room) begin
      len_next = LEN_W'(usage_x);
    end else if (room < max_x) begin
      len_next = LEN_W'(room);
    end else begin
      len_next = LEN_W'(max_x);
    end
  end

`ifdef PBM_DMA_FLUSH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(FLUSH_CYCLES + 1);
  logic [TW-1:0] flush_timer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_timer <= '0;
    end else if (start || (i_pbm_usage == '0) || (i_pbm_usage >= UW'(MAX_BURST))) begin
      flush_timer <= '0;
    end else if ((state == IDLE) && (flush_timer < TW'(FLUSH_CYCLES))) begin
      flush_timer <= flush_timer + TW'(1);
    end
  end

  assign flush_due = (flush_timer == TW'(FLUSH_CYCLES));
`else
  assign flush_due = 1'b0;
`endif

  assign eligible = i_enable && (i_pbm_usage != '0) &&
                    ((i_pbm_usage >= UW'(MAX_BURST)) || flush_due);

  // A popped word is either in flight or in the FIFO; both consume a credit.
  assign fill        = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign prefetch_ok = (issued < len) && !i_pbm_rd_empty && (fill < (CW+1)'(FIFO_DEPTH));
  assign last_beat   = (beats == len - LEN_W'(1));
  assign ptr_sum     = 17'(wr_ptr) + 17'(len);

  // Words arriving after a reset belong to an abandoned burst and are dropped.
  assign push     = i_pbm_rd_valid && (state != IDLE);
  assign dat_fire = o_dat_valid && i_dat_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    done        = 1'b0;
    o_cmd_valid = 1'b0;
    o_dat_valid = 1'b0;
    o_dat_last  = 1'b0;
    o_pbm_rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (eligible) begin
          state_next = CMD;
          start      = 1'b1;
        end
      end
      CMD: begin
        o_cmd_valid = 1'b1;
        o_pbm_rd_en = prefetch_ok;
        if (i_cmd_ready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        o_pbm_rd_en = prefetch_ok;
        o_dat_valid = !fifo_empty;
        o_dat_last  = !fifo_empty && last_beat;
        if (!fifo_empty && i_dat_ready && last_beat) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      len           <= '0;
      addr          <= '0;
      issued        <= '0;
      beats         <= '0;
      inflight      <= 1'b0;
      o_words_total <= '0;
    end else begin
      inflight <= o_pbm_rd_en;
      if (start) begin
        len    <= len_next;
        addr   <= i_base_addr + ADDR_WIDTH'(wr_ptr) * ADDR_WIDTH'(BPW);
        issued <= '0;
        beats  <= '0;
      end
      if (o_pbm_rd_en) begin
        issued <= issued + LEN_W'(1);
      end
      if (dat_fire) begin
        beats <= beats + LEN_W'(1);
      end
      if (done) begin
        wr_ptr        <= (ptr_sum >= 17'(i_ring_words)) ? '0 : 16'(ptr_sum);
        o_words_total <= o_words_total + 32'(len);
      end
    end
  end

  pbm_prefetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (i_pbm_rd_data),
    .pop       (dat_fire),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign o_busy     = (state != IDLE);
  assign o_cmd_addr = o_cmd_valid ? addr : '0;
  assign o_cmd_len  = o_cmd_valid ? len  : '0;
  assign o_dat_data = o_dat_valid ? fifo_head : '0;

endmodule

// File: tb/tb_pbm_dma_reader.sv
// tb_pbm_dma_reader: directed bench for pbm_dma_reader with a behavioural PBM
// (pop counter plus sequential data pattern) and negedge output monitor.
// Honours PBM_DMA_FLUSH_TIMEOUT_EN for the partial-burst flush case.
module tb_pbm_dma_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] base_addr;
  logic [15:0] ring_words;
  logic        pbm_rd_en;
  logic [31:0] pbm_rd_data;
  logic        pbm_rd_valid;
  logic        pbm_rd_empty;
  logic [14:0] pbm_usage;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        dat_valid, dat_ready;
  logic [31:0] dat_data;
  logic        dat_last;
  logic        busy;
  logic [31:0] words_total;

  int n_checks = 0;
  int n_fail   = 0;
  int added    = 0;
  int popped   = 0;
  int exp_next = 0;
  int beat_total = 0;
  int max_out  = 0;
  bit bp_mode  = 1'b0;

  logic [31:0] cmd_addr_q[$];
  int          cmd_len_q[$];
  logic [31:0] dat_q[$];
  bit          last_q[$];

  initial forever #5 clk = ~clk;

  pbm_dma_reader #(
    .DATA_WIDTH     (32),
    .PBM_ADDR_WIDTH (14),
    .ADDR_WIDTH     (32),
    .MAX_BURST      (16),
    .FIFO_DEPTH     (4),
    .FLUSH_CYCLES   (256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_base_addr    (base_addr),
    .i_ring_words   (ring_words),
    .o_pbm_rd_en    (pbm_rd_en),
    .i_pbm_rd_data  (pbm_rd_data),
    .i_pbm_rd_valid (pbm_rd_valid),
    .i_pbm_rd_empty (pbm_rd_empty),
    .i_pbm_usage    (pbm_usage),
    .o_cmd_valid    (cmd_valid),
    .i_cmd_ready    (cmd_ready),
    .o_cmd_addr     (cmd_addr),
    .o_cmd_len      (cmd_len),
    .o_dat_valid    (dat_valid),
    .i_dat_ready    (dat_ready),
    .o_dat_data     (dat_data),
    .o_dat_last     (dat_last),
    .o_busy         (busy),
    .o_words_total  (words_total)
  );

  assign pbm_usage    = 15'(added - popped);
  assign pbm_rd_empty = (added == popped);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // PBM model: a pop seen before an edge returns data one cycle later.
  initial begin
    bit pend;
    pbm_rd_valid = 1'b0;
    pbm_rd_data  = '0;
    forever begin
      @(negedge clk);
      pend = pbm_rd_en;
      @(posedge clk);
      #1;
      pbm_rd_valid = pend;
      if (pend) begin
        pbm_rd_data = 32'hD000_0000 + popped;
        popped++;
      end
    end
  end

  // Data-side ready: always high, or high one cycle in three.
  initial begin
    int cyc = 0;
    dat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      dat_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Monitor: records handshakes and words held between pop and delivery.
  initial begin
    forever begin
      @(negedge clk);
      if (popped - beat_total > max_out) max_out = popped - beat_total;
      if (cmd_valid && cmd_ready) begin
        cmd_addr_q.push_back(cmd_addr);
        cmd_len_q.push_back(int'(cmd_len));
      end
      if (dat_valid && dat_ready) begin
        dat_q.push_back(dat_data);
        last_q.push_back(dat_last);
        beat_total++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmds(input int n);
    int b = 0;
    while (cmd_addr_q.size() < n && b < 600) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [31:0] a, input int l);
    check({tag, "_avail"}, 32'(cmd_addr_q.size() > 0), 32'd1);
    if (cmd_addr_q.size() > 0) begin
      check({tag, "_addr"}, cmd_addr_q.pop_front(), a);
      check({tag, "_len"}, 32'(cmd_len_q.pop_front()), 32'(l));
    end
  endtask

  // Consumes n beats; bursts are l0, l1, l2 beats long in that order.
  task automatic drain(input string tag, input int n, input int l0, input int l1, input int l2);
    int b = 0;
    int bad_data = 0;
    int bad_last = 0;
    int pos = 0;
    int idx = 0;
    int blen = l0;
    logic [31:0] d;
    bit l;
    while (dat_q.size() < n && b < 2000) begin
      @(negedge clk);
      b++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_beats"}, 32'(dat_q.size()), 32'(n));
    for (int i = 0; i < n && dat_q.size() > 0; i++) begin
      d = dat_q.pop_front();
      l = last_q.pop_front();
      if (d != 32'hD000_0000 + 32'(exp_next)) bad_data++;
      exp_next++;
      pos++;
      if (l != (pos == blen)) bad_last++;
      if (pos == blen) begin
        pos = 0;
        idx++;
        blen = (idx == 1) ? l1 : l2;
      end
    end
    check({tag, "_order"}, 32'(bad_data), 32'd0);
    check({tag, "_last"}, 32'(bad_last), 32'd0);
  endtask

  initial begin
    int b;
    int p0;
    int bad;
    rst_n      = 1'b0;
    enable     = 1'b0;
    base_addr  = 32'h1000;
    ring_words = 16'd64;
    cmd_ready  = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_dat_valid", 32'(dat_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(pbm_rd_en), 32'd0);
    check("rst_total", words_total, 32'd0);

    // Full bursts at consecutive ring positions
    step();
    rst_n  = 1'b1;
    enable = 1'b1;
    added += 16;
    wait_cmds(1);
    expect_cmd("t1_cmd0", 32'h1000, 16);
    drain("t1_d0", 16, 16, 0, 0);
    check("t1_total0", words_total, 32'd16);
    step();
    added += 16;
    wait_cmds(1);
    expect_cmd("t1_cmd1", 32'h1040, 16);
    drain("t1_d1", 16, 16, 0, 0);
    check("t1_total1", words_total, 32'd32);

    // Data backpressure, one ready cycle in three
    step();
    bp_mode = 1'b1;
    max_out = 0;
    added += 32;
    drain("t2", 32, 16, 16, 0);
    expect_cmd("t2_cmd0", 32'h1080, 16);
    expect_cmd("t2_cmd1", 32'h10C0, 16);
    check("t2_max_outstanding", 32'(max_out), 32'd4);
    check("t2_total", words_total, 32'd64);
    bp_mode = 1'b0;

    // Ring wrap with a 24-word ring
    step();
    ring_words = 16'd24;
    added += 40;
    drain("t3", 40, 16, 8, 16);
    expect_cmd("t3_cmd0", 32'h1000, 16);
    expect_cmd("t3_cmd1", 32'h1040, 8);
    expect_cmd("t3_cmd2", 32'h1000, 16);
    check("t3_total", words_total, 32'd104);

    // Command stall: prefetch stops at FIFO depth
    step();
    ring_words = 16'd64;
    cmd_ready  = 1'b0;
    p0 = popped;
    added += 16;
    b = 0;
    while (!cmd_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("t4_cmd_seen", 32'(cmd_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_addr !== 32'h1040 || cmd_len !== 9'd16 || dat_valid !== 1'b0) bad++;
    end
    check("t4_stall_stable", 32'(bad), 32'd0);
    check("t4_prefetched", 32'(popped - p0), 32'd4);
    step();
    cmd_ready = 1'b1;
    drain("t4", 16, 16, 0, 0);
    expect_cmd("t4_cmd", 32'h1040, 16);
    check("t4_total", words_total, 32'd120);

    // Reset during the data phase at beat 7
    step();
    p0 = beat_total;
    added += 16;
    b = 0;
    while (beat_total - p0 < 7 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("t5_reached_beat7", 32'(beat_total - p0 >= 7), 32'd1);
    step();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_cmd_valid", 32'(cmd_valid), 32'd0);
    check("t5_cmd_addr", cmd_addr, 32'd0);
    check("t5_cmd_len", 32'(cmd_len), 32'd0);
    check("t5_dat_valid", 32'(dat_valid), 32'd0);
    check("t5_dat_data", dat_data, 32'd0);
    check("t5_dat_last", 32'(dat_last), 32'd0);
    check("t5_rd_en", 32'(pbm_rd_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_total", words_total, 32'd0);
    step();
    rst_n = 1'b1;
    added = popped;
    exp_next = popped;
    dat_q.delete();
    last_q.delete();
    cmd_addr_q.delete();
    cmd_len_q.delete();
    p0 = popped;
    added += 10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || pbm_rd_en) bad++;
    end
    check("t5_idle_below_burst", 32'(bad), 32'd0);
    check("t5_no_pops", 32'(popped - p0), 32'd0);
    step();
    added += 6;
    wait_cmds(1);
    expect_cmd("t5_cmd", 32'h1000, 16);
    drain("t5", 16, 16, 0, 0);
    check("t5_total_after", words_total, 32'd16);

    // Partial burst flush
    step();
    added += 5;
`ifdef PBM_DMA_FLUSH_TIMEOUT_EN
    b = 0;
    while (!cmd_valid && b < 400) begin
      @(negedge clk);
      b++;
    end
    check("t6_flush_cmd", 32'(cmd_valid), 32'd1);
    check("t6_flush_len", 32'(cmd_len), 32'd5);
    check("t6_flush_addr", cmd_addr, 32'h1040);
    check("t6_flush_delay", 32'(b >= 250 && b <= 270), 32'd1);
    drain("t6", 5, 5, 0, 0);
    check("t6_total", words_total, 32'd21);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmd_valid || busy) bad++;
    end
    check("t6_no_flush", 32'(bad), 32'd0);
    check("t6_no_pops", 32'(added - popped), 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
